// File: rtl/stream_mux_pkg.sv
// Shared types and helpers for the stream multiplexer and its round-robin arbiter.
package stream_mux_pkg;

   typedef enum logic {
      MODE_SEL = 1'b0,
      MODE_RR  = 1'b1
   } arb_mode_e;

   function automatic int sel_width(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin arbiter: one-hot grant to the first requester at or after rr_ptr,
// pointer moves past the granted channel only on a completed transfer.
module rr_arbiter
   import stream_mux_pkg::*;
#(
   parameter int N = 4
) (
   input  logic         clk,
   input  logic         rst,
   input  logic [N-1:0] req,
   input  logic         advance,
   output logic [N-1:0] grant_oh
);

   localparam int PTR_W = sel_width(N);

   logic [PTR_W-1:0] rr_ptr_r;
   logic [PTR_W-1:0] grant_idx_s;
   logic [N-1:0]     grant_oh_s;
   logic             found_s;
   logic             hit_s;

   // Scan offsets 0..N-1 from the pointer; the first matching requester wins.
   always_comb begin
      grant_oh_s  = '0;
      grant_idx_s = '0;
      found_s     = 1'b0;
      hit_s       = 1'b0;
      for (int k = 0; k < N; k++) begin
         for (int i = 0; i < N; i++) begin
            hit_s          = !found_s && req[i] && (i == ((int'(rr_ptr_r) + k) % N));
            grant_oh_s[i]  = grant_oh_s[i] | hit_s;
            grant_idx_s    = hit_s ? PTR_W'(i) : grant_idx_s;
            found_s        = found_s | hit_s;
         end
      end
   end

   // Pointer register: moves one past the winner, wrapping at N-1.
   always_ff @(posedge clk) begin
      if (rst) begin
         rr_ptr_r <= '0;
      end else if (advance && found_s) begin
         rr_ptr_r <= (grant_idx_s == PTR_W'(N - 1)) ? '0 : grant_idx_s + PTR_W'(1);
      end else begin
         rr_ptr_r <= rr_ptr_r;
      end
   end

   assign grant_oh = grant_oh_s;

endmodule

// File: rtl/stream_mux.sv
// N-channel valid/ready stream multiplexer with a registered output stage,
// selecting by external sel or by round-robin arbitration.
module stream_mux
   import stream_mux_pkg::*;
#(
   parameter  int WIDTH    = 8,
   parameter  int NUM_CH   = 4,
   parameter  int ARB_MODE = 0,
   localparam int SEL_W    = sel_width(NUM_CH)
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [WIDTH-1:0]  in_data [NUM_CH],
   input  logic [NUM_CH-1:0] in_valid,
   output logic [NUM_CH-1:0] in_ready,
   input  logic [SEL_W-1:0]  sel,
   output logic [WIDTH-1:0]  out_data,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [SEL_W-1:0]  out_ch
);

   logic              load_s;
   logic [NUM_CH-1:0] grant_oh_s;
   logic [NUM_CH-1:0] xfer_vec_s;
   logic              xfer_s;
   logic [WIDTH-1:0]  mux_data_s;
   logic [SEL_W-1:0]  mux_ch_s;

   assign load_s     = !out_valid || out_ready;
   assign in_ready   = (load_s && !rst) ? grant_oh_s : '0;
   assign xfer_vec_s = in_valid & in_ready;
   assign xfer_s     = |xfer_vec_s;

   generate
      if (ARB_MODE == int'(MODE_RR)) begin : g_rr
         rr_arbiter #(
            .N (NUM_CH)
         ) u_arb (
            .clk      (clk),
            .rst      (rst),
            .req      (in_valid),
            .advance  (xfer_s),
            .grant_oh (grant_oh_s)
         );
      end else begin : g_sel
         // Decode sel; out-of-range values leave every channel un-granted.
         always_comb begin
            grant_oh_s = '0;
            for (int i = 0; i < NUM_CH; i++) begin
               grant_oh_s[i] = (sel == SEL_W'(i));
            end
         end
      end
   endgenerate

   // AND-OR mux so that X on non-transferring channels cannot reach out_data.
   always_comb begin
      mux_data_s = '0;
      mux_ch_s   = '0;
      for (int i = 0; i < NUM_CH; i++) begin
         mux_data_s = mux_data_s | (in_data[i] & {WIDTH{xfer_vec_s[i]}});
         mux_ch_s   = mux_ch_s | (xfer_vec_s[i] ? SEL_W'(i) : '0);
      end
   end

   // Output register: load on transfer, drain when empty-slot, hold under backpressure.
   always_ff @(posedge clk) begin
      if (rst) begin
         out_data  <= '0;
         out_ch    <= '0;
         out_valid <= 1'b0;
      end else if (load_s) begin
         if (xfer_s) begin
            out_data  <= mux_data_s;
            out_ch    <= mux_ch_s;
            out_valid <= 1'b1;
         end else begin
            out_data  <= out_data;
            out_ch    <= out_ch;
            out_valid <= 1'b0;
         end
      end else begin
         out_data  <= out_data;
         out_ch    <= out_ch;
         out_valid <= out_valid;
      end
   end

endmodule
